immu_ifetch_resp: RTL

//  Responder for the IFU instruction-fetch port (mmu_i_*). Translates the fetch VA (DA/DMW0/DMW1/TLB),

---
 rtl/immu_ifetch_resp_if.sv | 33 +++
 rtl/immu_ifetch_resp.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/immu_ifetch_resp_if.sv
// ---------------------------------------------------------------------------
// immu_ifetch_resp_if
// Instruction-fetch port between the IFU (master) and the fetch responder
// (slave).
//   mmu_i_valid / mmu_i_addr       : fetch request and its VA (from the IFU)
//   mmu_i_addr_ok                  : request accepted this cycle
//   mmu_i_double                   : two instructions will be returned
//   mmu_i_data_ok / mmu_i_rdata    : one response per accepted request
//   mmu_i_tlbr / mmu_i_pif / _ppi  : fetch translation exceptions
// ---------------------------------------------------------------------------
interface immu_ifetch_resp_if;
   logic        mmu_i_valid;
   logic [31:0] mmu_i_addr;
   logic        mmu_i_addr_ok;
   logic        mmu_i_double;
   logic        mmu_i_data_ok;
   logic [63:0] mmu_i_rdata;
   logic        mmu_i_tlbr;
   logic        mmu_i_pif;
   logic        mmu_i_ppi;

   modport master (
      output mmu_i_valid, mmu_i_addr,
      input  mmu_i_addr_ok, mmu_i_double, mmu_i_data_ok, mmu_i_rdata,
             mmu_i_tlbr, mmu_i_pif, mmu_i_ppi
   );

   modport slave (
      input  mmu_i_valid, mmu_i_addr,
      output mmu_i_addr_ok, mmu_i_double, mmu_i_data_ok, mmu_i_rdata,
             mmu_i_tlbr, mmu_i_pif, mmu_i_ppi
   );
endinterface

// File: rtl/immu_ifetch_resp.sv
// ---------------------------------------------------------------------------
// immu_ifetch_resp
// Responder for the IFU instruction-fetch port. Translates the fetch VA
// (direct address, DMW0, DMW1, then TLB), flags TLB refill / page invalid /
// privilege violation combinationally, fetches one 8-byte block from the
// I-side memory port and returns one or two instructions per request.
//
// Ports
//   clk, resetn          : clock, asynchronous active-low reset
//   ifc (slave)          : IFU fetch port (mmu_i_*)
//   csr_crmd_da/_plv     : direct-address mode, current privilege level
//   csr_dmw0/1           : direct mapping windows
//   tlb_s_*              : TLB search request (vppn, bit12) and result
//   mem_*                : I-side memory read port (8-byte aligned blocks)
//
// Parameter DOUBLE_FETCH : 1 grants a double fetch when VA[2]==0.
// Optional feature macro IMMU_DATA_BYPASS_EN : the response is forwarded in
// the same cycle as mem_data_ok (latency 2) instead of through the
// registered RESP state (latency 3).
// ---------------------------------------------------------------------------
module immu_ifetch_resp #(
   parameter int DOUBLE_FETCH = 1
) (
   input  logic               clk,
   input  logic               resetn,
   immu_ifetch_resp_if.slave  ifc,
   input  logic               csr_crmd_da,
   input  logic [1:0]         csr_crmd_plv,
   input  logic [31:0]        csr_dmw0,
   input  logic [31:0]        csr_dmw1,
   output logic [18:0]        tlb_s_vppn,
   output logic               tlb_s_va_bit12,
   input  logic               tlb_s_found,
   input  logic [19:0]        tlb_s_ppn,
   input  logic [5:0]         tlb_s_ps,
   input  logic               tlb_s_v,
   input  logic [1:0]         tlb_s_plv,
   output logic               mem_req,
   output logic [31:0]        mem_addr,
   input  logic               mem_addr_ok,
   input  logic               mem_data_ok,
   input  logic [63:0]        mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [28:0] r_pa_hi;
   logic        r_va2;
   logic        r_double;
   logic [63:0] r_rdata;

   logic [31:0] w_va;
   logic [31:0] w_pa;
   logic        w_dmw0_hit;
   logic        w_dmw1_hit;
   logic        w_tlbr;
   logic        w_pif;
   logic        w_ppi;
   logic        w_exc;
   logic        w_double;
   logic        w_accept;
   logic        w_data_ok;
   logic        w_capture;

   // A VA[2]==1 fetch only has one instruction in the upper half of the block.
   function automatic logic [63:0] f_select(input logic va2, input logic [63:0] blk);
      logic [63:0] res;
      if (va2) begin
         res = {32'h0000_0000, blk[63:32]};
      end else begin
         res = blk;
      end
      return res;
   endfunction

   assign w_va           = ifc.mmu_i_addr;
   assign tlb_s_vppn     = w_va[31:13];
   assign tlb_s_va_bit12 = w_va[12];

   assign w_dmw0_hit = (w_va[31:29] == csr_dmw0[31:29]) &&
                       ((csr_dmw0[0] && (csr_crmd_plv == 2'd0)) ||
                        (csr_dmw0[3] && (csr_crmd_plv == 2'd3)));
   assign w_dmw1_hit = (w_va[31:29] == csr_dmw1[31:29]) &&
                       ((csr_dmw1[0] && (csr_crmd_plv == 2'd0)) ||
                        (csr_dmw1[3] && (csr_crmd_plv == 2'd3)));

   // Address translation and exception detection; exceptions exist only on the TLB path.
   always_comb begin
      w_pa   = 32'h0000_0000;
      w_tlbr = 1'b0;
      w_pif  = 1'b0;
      w_ppi  = 1'b0;
      if (csr_crmd_da) begin
         w_pa = w_va;
      end else if (w_dmw0_hit) begin
         w_pa = {csr_dmw0[27:25], w_va[28:0]};
      end else if (w_dmw1_hit) begin
         w_pa = {csr_dmw1[27:25], w_va[28:0]};
      end else begin
         if (tlb_s_ps == 6'd12) begin
            w_pa = {tlb_s_ppn, w_va[11:0]};
         end else begin
            w_pa = {tlb_s_ppn[19:9], w_va[20:0]};
         end
         w_tlbr = ~tlb_s_found;
         w_pif  = tlb_s_found & ~tlb_s_v;
         w_ppi  = tlb_s_found & tlb_s_v & (csr_crmd_plv > tlb_s_plv);
      end
   end

   assign w_exc    = w_tlbr | w_pif | w_ppi;
   assign w_double = (DOUBLE_FETCH != 0) & ~w_va[2];

   // Next-state and handshake decode of the fetch FSM.
   always_comb begin
      w_next    = r_state;
      w_accept  = 1'b0;
      w_data_ok = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = ifc.mmu_i_valid & ~w_exc;
            if (w_accept) begin
               w_next = S_REQ;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_REQ: begin
            if (mem_addr_ok) begin
               w_next = S_WAIT;
            end else begin
               w_next = S_REQ;
            end
         end
         S_WAIT: begin
            if (mem_data_ok) begin
               w_capture = 1'b1;
`ifdef IMMU_DATA_BYPASS_EN
               // Forward the block directly; a new fetch may be taken in the same cycle.
               w_data_ok = 1'b1;
               w_accept  = ifc.mmu_i_valid & ~w_exc;
               if (w_accept) begin
                  w_next = S_REQ;
               end else begin
                  w_next = S_IDLE;
               end
`else
               w_next = S_RESP;
`endif
            end else begin
               w_next = S_WAIT;
            end
         end
         S_RESP: begin
            w_data_ok = 1'b1;
            w_accept  = ifc.mmu_i_valid & ~w_exc;
            if (w_accept) begin
               w_next = S_REQ;
            end else begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State register, request latches and captured response block.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_pa_hi  <= 29'h0;
         r_va2    <= 1'b0;
         r_double <= 1'b0;
         r_rdata  <= 64'h0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_pa_hi  <= w_pa[31:3];
            r_va2    <= w_va[2];
            r_double <= w_double;
         end
         if (w_capture) begin
            r_rdata <= f_select(r_va2, mem_rdata);
         end
      end
   end

   assign ifc.mmu_i_addr_ok = w_accept;
   assign ifc.mmu_i_double  = w_double;
   assign ifc.mmu_i_tlbr    = w_tlbr;
   assign ifc.mmu_i_pif     = w_pif;
   assign ifc.mmu_i_ppi     = w_ppi;
   assign ifc.mmu_i_data_ok = w_data_ok;
`ifdef IMMU_DATA_BYPASS_EN
   assign ifc.mmu_i_rdata   = w_capture ? f_select(r_va2, mem_rdata) : r_rdata;
`else
   assign ifc.mmu_i_rdata   = r_rdata;
`endif
   assign mem_req  = (r_state == S_REQ);
   assign mem_addr = {r_pa_hi, 3'b000};

   // Window fields not needed for fetch translation (MAT, reserved bits).
   logic w_unused;
   assign w_unused = ^{csr_dmw0[28], csr_dmw0[24:4], csr_dmw0[2:1],
                       csr_dmw1[28], csr_dmw1[24:4], csr_dmw1[2:1],
                       w_pa[2:0], r_double};

endmodule
